// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and frame defaults used by rx, tx and baud generator.
// Pure constants and types; no logic, no latency, no flow control.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; 2 clk latency, no backpressure.
// Both flops reset to RST_VAL so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling; byte/framing-error pulse one clk after the stop sample.
// No backpressure: data_out is held only until the next good frame overwrites it.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_os_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_FULL  = BW'(DATA_BITS);

  logic                 w_rx_s;
  logic                 r_rx_d;

  rx_state_t            r_state,      w_state_nxt;
  logic [TW-1:0]        r_tick_cnt,   w_tick_nxt;
  logic [BW-1:0]        r_bit_cnt,    w_bit_nxt;
  logic [BW-1:0]        w_bit_inc;
  logic [DATA_BITS-1:0] r_shift,      w_shift_nxt;
  logic [DATA_BITS-1:0] r_data_out,   w_dout_nxt;
  logic                 r_data_valid, w_valid_nxt;
  logic                 r_frame_err,  w_ferr_nxt;
  logic                 r_busy,       w_busy_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_rx),
    .o_q (w_rx_s)
  );

  assign w_bit_inc = r_bit_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_d       <= 1'b1;
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_d       <= w_rx_s;
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_data_out   <= w_dout_nxt;
      r_data_valid <= w_valid_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_data_out;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_busy_nxt  = r_busy;

    case (r_state)
      // Edge-triggered so a line stuck low cannot start a stream of frames.
      IDLE: begin
        if (r_rx_d && !w_rx_s) begin
          w_tick_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (i_os_tick) begin
          if (r_tick_cnt == TICK_MID) begin
            w_tick_nxt = '0;
            if (!w_rx_s) begin
              w_bit_nxt   = '0;
              w_state_nxt = DATA;
            end else begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_os_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (w_bit_inc == BIT_FULL) begin
              w_bit_nxt   = '0;
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = w_bit_inc;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_os_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
            if (w_rx_s) begin
              w_dout_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ferr_nxt = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random 8N1 traffic against a frame-level model.
// Expected bytes, error kinds and pulse times come from the bit sequence the bench itself drives.
module tb_uart_rx;

  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int TDIV   = 4;
  localparam int BITC   = OS * TDIV;
  localparam int LAT    = OS / 2 + OS * (DB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          os_tick;
  logic          rx;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_os_tick    (os_tick),
    .i_rx         (rx),
    .o_data_out   (data_out),
    .o_data_valid (data_valid),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          err;
    logic [7:0]  dat;
    bit          timed;
    int          tick;
  } ev_t;

  ev_t        exp_q[$];
  int         vld_ticks[$];
  int         tb_ticks = 0;
  logic [7:0] exp_dout = 8'h00;
  bit         prev_pulse = 1'b0;

  initial begin
    int div;
    div = 0;
    os_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 os_tick = (div == TDIV - 1);
      div = (div + 1) % TDIV;
    end
  end

  always @(posedge clk) if (os_tick) tb_ticks <= tb_ticks + 1;

  // Frame-level scoreboard: each observed pulse must match the oldest frame the driver sent.
  always @(negedge clk) begin
    ev_t e;
    if (prev_pulse) chk("pulse_len", 32'(data_valid | frame_err), 0);
    prev_pulse <= data_valid | frame_err;
    if (rst) exp_dout <= 8'h00;
    if (!rst && (data_valid || frame_err)) begin
      chk("excl", 32'(data_valid & frame_err), 0);
      chk("busy_at_pulse", 32'(busy), 0);
      if (data_valid) vld_ticks.push_back(tb_ticks);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("kind_ferr", 32'(frame_err), 32'(e.err));
        if (!e.err) begin
          chk("data_out", 32'(data_out), 32'(e.dat));
          exp_dout <= e.dat;
        end else begin
          chk("data_out_held", 32'(data_out), 32'(exp_dout));
        end
        if (e.timed) chk("latency", tb_ticks - e.tick, LAT);
      end
    end
  end

  task automatic drive_bit(input logic v, input int clks, input bit chk_busy);
    @(posedge clk);
    #1 rx = v;
    repeat (clks / 2) @(posedge clk);
    #1 if (chk_busy) chk("busy_in_frame", 32'(busy), 1);
    repeat (clks - 1 - clks / 2) @(posedge clk);
  endtask

  task automatic idle(input int clks);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (clks - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int clks, input bit timed);
    ev_t e;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    e.err   = !stop;
    e.dat   = d;
    e.timed = timed;
    e.tick  = tb_ticks;
    exp_q.push_back(e);
    repeat (clks - 4) @(posedge clk);
    for (int i = 0; i < DB; i++) drive_bit(d[i], clks, 1'b1);
    drive_bit(stop, clks, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    int         n0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(40);

    send_frame(8'hA5, 1'b1, BITC, 1'b1);
    idle(BITC);
    chk("a5_out", 32'(data_out), 32'h00A5);

    // Short low pulse: accepted as an edge, rejected at the mid-bit sample.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("glitch_busy_hi", 32'(busy), 1);
    repeat (4 * TDIV - 9) @(posedge clk);
    #1 rx = 1'b1;
    repeat (60) @(posedge clk);
    #1 chk("glitch_busy_lo", 32'(busy), 0);
    idle(BITC);

    send_frame(8'h3C, 1'b0, BITC, 1'b1);
    for (int k = 0; k < 3; k++) begin
      repeat (BITC) @(posedge clk);
      #1 chk("low_hold_busy", 32'(busy), 0);
    end
    idle(BITC);
    chk("ferr_out_kept", 32'(data_out), 32'h00A5);

    n0 = vld_ticks.size();
    send_frame(8'h00, 1'b1, BITC, 1'b1);
    send_frame(8'hFF, 1'b1, BITC, 1'b1);
    idle(BITC);
    chk("b2b_count", vld_ticks.size() - n0, 2);
    chk("b2b_gap", (vld_ticks.size() >= n0 + 2) ? vld_ticks[n0 + 1] - vld_ticks[n0] : -1, OS * (DB + 2));
    chk("b2b_last", 32'(data_out), 32'h00FF);

    d = 8'h5A;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BITC - 1) @(posedge clk);
    for (int i = 0; i < 3; i++) drive_bit(d[i], BITC, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", 32'(data_out), 0);
    chk("mid_rst_valid", 32'(data_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(BITC);
    chk("mid_rst_no_pend", exp_q.size(), 0);
    send_frame(8'h5A, 1'b1, BITC, 1'b1);
    idle(BITC);
    chk("after_rst_5a", 32'(data_out), 32'h005A);

    // +3% baud shortens each bit to ~62 clk, -3% lengthens it to ~66 clk.
    send_frame(8'h55, 1'b1, BITC - 2, 1'b0);
    idle(BITC);
    send_frame(8'h55, 1'b1, BITC + 2, 1'b0);
    idle(BITC);
    chk("margin_55", 32'(data_out), 32'h0055);

    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(4) != 0);
      send_frame(d, stop, BITC, 1'b1);
      if (!stop) idle(8 + $urandom_range(40));
      else if ($urandom_range(1) == 1) idle(1 + $urandom_range(40));
    end
    idle(2 * BITC);
    chk("leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It samples the line with a 16× oversampling tick from the shared baud generator and validates the start bit at mid-bit. It delivers each received byte with a one-cycle valid strobe and flags framing errors. It is the receive half of the UART block, sitting between the external RX pin and the processor-side byte consumer.

## Interface
- OVERSAMPLE, 16: os_tick pulses per bit period; even, ≥ 4.
- DATA_BITS, 8: data bits per frame.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- os_tick  in  1  single-cycle pulse at OVERSAMPLE × baud rate, synchronous to clk.
- rx  in  1  raw serial line; idle high; asynchronous to clk.
- data_out  out  DATA_BITS  last correctly received byte; held until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- busy  out  1  high from start-bit detection until the frame ends.

## Operation
- rx passes through a 2-FF synchronizer (both flops reset to 1) to give rx_s. A third flop rx_d gives edge detect; it also resets to 1.
- Reset values: data_out=0, data_valid=0, frame_err=0, busy=0. State is IDLE, the tick counter is 0, the bit counter is 0, and the shift register is 0.
- Counters advance only on clk cycles with os_tick=1.
- IDLE
  - Trigger: falling edge (rx_d=1, rx_s=0).
  - Action: clear the tick counter, set busy=1, go to START.
  - A line held low does not retrigger, because an edge is required.
- START
  - On the os_tick that makes the tick count reach OVERSAMPLE/2 (mid-bit), sample rx_s.
  - rx_s=0: clear the tick counter, go to DATA.
  - rx_s=1: treat as a glitch; set busy=0 and go to IDLE with no pulse.
- DATA
  - Every OVERSAMPLE os_ticks, sample rx_s and shift it into the MSB of the shift register (right shift, so the first bit ends up at bit 0).
  - After DATA_BITS samples, go to STOP.
- STOP
  - After OVERSAMPLE os_ticks, sample rx_s.
  - rx_s=1: data_out ← shift register, data_valid=1 for one cycle.
  - rx_s=0: frame_err=1 for one cycle; data_out is unchanged.
  - In both cases set busy=0 and go to IDLE.
- Line activity between sample points is ignored.
- No output buffering: the consumer must capture data_out before the next data_valid.

## Timing
- Synchronizer latency: 2 clk cycles from rx to rx_s.
- data_valid/frame_err assert on the clk edge after the os_tick that samples the stop bit.
- That edge falls 8 + 16·(DATA_BITS+1) = 152 os_ticks after the synchronized start edge (at defaults).
- data_valid and frame_err are mutually exclusive and last exactly one clk cycle.
- busy falls in the same cycle as the data_valid/frame_err pulse.
- Back-to-back frames: a falling edge arriving after the stop sample starts the next frame. No idle bit is required beyond the stop bit.
- Tick counter width is clog2(OVERSAMPLE); it wraps to 0 at OVERSAMPLE−1 in DATA/STOP. Bit counter width is clog2(DATA_BITS+1).
- Reset mid-frame returns everything to reset values immediately. The partial frame is discarded with no pulse.
- os_tick is never asserted on consecutive clk cycles; the block need not handle that case.

## Structure
- Shared package/include uart_pkg:
  - state encodings IDLE/START/DATA/STOP (2-bit localparams);
  - default OVERSAMPLE and DATA_BITS, shared with the transmitter and baud generator.
- One sub-module: sync_2ff (parameterized reset value, default 1), reusable for other async inputs.
- FSM, counters and the shift register stay in uart_rx.

## Test plan
- Frame 0xA5 at OVERSAMPLE=16:
  - data_out=0xA5; data_valid high exactly 1 cycle, 152 os_ticks after the synchronized start edge; frame_err=0.
  - busy high throughout the frame, low in the valid cycle.
- Glitch: rx low for 4 os_ticks, then high -> no data_valid, no frame_err; busy returns to 0 at the mid-bit tick; state is IDLE.
- Frame 0x3C with stop bit 0, following a good 0xA5 -> frame_err pulses 1 cycle; data_valid stays 0; data_out remains 0xA5. The line held low afterwards causes no new frame until a high→low edge.
- Back-to-back 0x00 then 0xFF, single stop bit each -> two data_valid pulses 160 os_ticks apart, with data_out 0x00 then 0xFF.
- Reset asserted after 3 data bits of 0x5A -> busy=0 and data_out=0 immediately, no pulse. A following 0x5A frame is received correctly.
- Sampling margin: 0x55 sent with the baud rate offset +3% and −3% -> 0x55 received, no frame_err in either case.
